id_stage_sequencer: RTL and testbench

Controls the IF/ID boundary of the 64-bit RISC-V pipeline. Holds one fetched instruction and its PC with a valid/ready handshake on both sides. Classifies the held instruction's opcode into the 3-bit format select that drives the immediate parser. Withholds the instruction from EX on a load-use hazard and discards it on a flush.

---
 rtl/id_stage_sequencer.sv | 102 ++++++++++
 tb/tb_id_stage_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_sequencer.sv
// IF/ID boundary register: holds one fetched instruction, classifies its immediate format and stalls on load-use hazards.
// Optional build macro ILLEGAL_OPCODE_EN enables id_illegal; when it is not defined, id_illegal is tied to 0.
module id_stage_sequencer #(
  parameter int          XLEN      = 64,
  parameter logic [2:0]  RESET_SEL = 3'd3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      imm_sel,
  output logic            id_illegal,
  output logic            seq_state
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;
  logic [2:0]        sel_dec;
  logic              known_op;
  logic              uses_rs1, uses_rs2;
  logic              hazard, out_fire, in_fire;

  // Immediate format decode of the held opcode; unknown opcodes fall back to R/none.
  always_comb begin
    sel_dec  = 3'd3;
    known_op = 1'b1;
    case (instr_q[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: sel_dec = 3'd0;
      7'b0110111, 7'b0010111: sel_dec = 3'd1;
      7'b0100011:             sel_dec = 3'd2;
      7'b0110011, 7'b0111011: sel_dec = 3'd3;
      7'b1100011:             sel_dec = 3'd4;
      7'b1101111:             sel_dec = 3'd5;
      default:                known_op = 1'b0;
    endcase
  end

  assign uses_rs1 = (sel_dec == 3'd0) || (sel_dec == 3'd2) || (sel_dec == 3'd3) || (sel_dec == 3'd4);
  assign uses_rs2 = (sel_dec == 3'd2) || (sel_dec == 3'd3) || (sel_dec == 3'd4);

  assign id_rs1 = instr_q[19:15];
  assign id_rs2 = instr_q[24:20];

  assign hazard = (state_q == FULL) && ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready upstream is granted only when the slot empties this cycle.
  assign id_valid = (state_q == FULL) && !hazard;
  assign out_fire = id_valid && ex_ready;
  assign if_ready = !flush && ((state_q == EMPTY) || out_fire);
  assign in_fire  = if_valid && if_ready;

  always_comb begin
    state_d = state_q;
    if (flush)         state_d = EMPTY;
    else if (in_fire)  state_d = FULL;
    else if (out_fire) state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      instr_q <= 32'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        instr_q <= if_instr;
        pc_q    <= if_pc;
      end
    end
  end

  assign id_instr  = instr_q;
  assign id_pc     = pc_q;
  assign imm_sel   = (state_q == FULL) ? sel_dec : RESET_SEL;
  assign seq_state = (state_q == FULL);

`ifdef ILLEGAL_OPCODE_EN
  assign id_illegal = (state_q == FULL) && !known_op;
`else
  logic unused_known;
  assign unused_known = known_op;
  assign id_illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_sequencer.sv
// Directed bench for id_stage_sequencer: reset, pass-through, load-use stall, flush and opcode decode.
module tb_id_stage_sequencer;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_valid, if_ready, flush, ex_ready, ex_is_load;
  logic [31:0]     if_instr, id_instr;
  logic [XLEN-1:0] if_pc, id_pc;
  logic [4:0]      ex_rd, id_rs1, id_rs2;
  logic            id_valid, id_illegal, seq_state;
  logic [2:0]      imm_sel;

  int passed = 0;
  int total  = 0;
  logic exp_ill;
  logic [31:0] seq_instr [4];
  logic [2:0]  seq_sel   [4];

  id_stage_sequencer #(.XLEN(XLEN), .RESET_SEL(3'd3)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .imm_sel(imm_sel), .id_illegal(id_illegal), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    reset = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
    ex_ready = 1'b1; ex_is_load = 0; ex_rd = 0;
    tick(); tick();
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_imm_sel", imm_sel, 3);
    check("rst_illegal", id_illegal, 0);
    check("rst_state", seq_state, 0);
    @(negedge clk); reset = 1'b0; settle();
    check("rst_if_ready", if_ready, 1);

    // addi x1, x0, 5
    offer(32'h00500093, 64'h1000);
    tick();
    if_valid = 0;
    check("addi_valid", id_valid, 1);
    check("addi_pc", id_pc, 64'h1000);
    check("addi_sel", imm_sel, 0);
    check("addi_rs1", id_rs1, 0);
    check("addi_rs2", id_rs2, 5);
    tick();
    check("addi_drained", id_valid, 0);

    // Back-to-back lui, sw, beq, jal at full throughput
    seq_instr[0] = 32'h123450B7; seq_sel[0] = 3'd1;
    seq_instr[1] = 32'h00112023; seq_sel[1] = 3'd2;
    seq_instr[2] = 32'h00208463; seq_sel[2] = 3'd4;
    seq_instr[3] = 32'h008000EF; seq_sel[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      offer(seq_instr[i], 64'h2000 + 64'(4 * i));
      settle();
      check($sformatf("b2b_if_ready%0d", i), if_ready, 1);
      @(posedge clk); #1;
      check($sformatf("b2b_valid%0d", i), id_valid, 1);
      check($sformatf("b2b_instr%0d", i), id_instr, seq_instr[i]);
      check($sformatf("b2b_pc%0d", i), id_pc, 64'h2000 + 64'(4 * i));
      check($sformatf("b2b_sel%0d", i), imm_sel, seq_sel[i]);
    end
    if_valid = 0;
    tick();
    check("b2b_drained", id_valid, 0);

    // add x3, x2, x1 with a load to x2 in EX: stall 3 cycles
    offer(32'h001101B3, 64'h3000);
    tick();
    if_valid = 0; ex_is_load = 1; ex_rd = 5'd2;
    settle();
    check("haz_valid0", id_valid, 0);
    check("haz_ready0", if_ready, 0);
    tick();
    check("haz_valid1", id_valid, 0);
    check("haz_ready1", if_ready, 0);
    tick();
    check("haz_valid2", id_valid, 0);
    check("haz_ready2", if_ready, 0);
    ex_is_load = 0;
    settle();
    check("haz_release_valid", id_valid, 1);
    check("haz_release_ready", if_ready, 1);
    check("haz_sel", imm_sel, 3);
    tick();
    check("haz_drained", id_valid, 0);
    check("empty_sel", imm_sel, 3);

    // Same add: load to x0 never stalls, load to rs2 does
    offer(32'h001101B3, 64'h3004);
    tick();
    if_valid = 0; ex_is_load = 1; ex_rd = 5'd0;
    settle();
    check("x0_no_stall", id_valid, 1);
    ex_rd = 5'd1;
    settle();
    check("rs2_stall", id_valid, 0);
    ex_is_load = 0;
    tick();
    check("rs2_drained", id_valid, 0);

    // lui has rs1 field = 8 but reads no registers
    offer(32'h123450B7, 64'h3008);
    tick();
    if_valid = 0; ex_is_load = 1; ex_rd = 5'd8;
    settle();
    check("lui_no_stall", id_valid, 1);
    ex_is_load = 0;
    tick();

    // Hold add with EX stalled, then flush while fetch offers lui
    offer(32'h001101B3, 64'h4000);
    tick();
    if_valid = 0; ex_ready = 0;
    tick();
    check("hold_valid1", id_valid, 1);
    check("hold_ready1", if_ready, 0);
    tick();
    check("hold_valid2", id_valid, 1);
    flush = 1'b1;
    offer(32'h123450B7, 64'h5000);
    settle();
    check("flush_if_ready", if_ready, 0);
    tick();
    flush = 0; if_valid = 0; ex_ready = 1;
    check("flush_valid", id_valid, 0);
    check("flush_sel", imm_sel, 3);
    check("flush_not_captured", id_instr, 32'h001101B3);
    check("flush_pc_kept", id_pc, 64'h4000);
    check("flush_state", seq_state, 0);

    // Unknown opcode
`ifdef ILLEGAL_OPCODE_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    offer(32'hFFFFFFFF, 64'h6000);
    tick();
    if_valid = 0;
    check("ill_flag", id_illegal, exp_ill);
    check("ill_sel", imm_sel, 3);
    check("ill_valid", id_valid, 1);
    tick();
    check("ill_cleared", id_illegal, 0);

    // Asynchronous reset while holding an instruction
    ex_ready = 0;
    offer(32'h00500093, 64'h7000);
    tick();
    if_valid = 0;
    check("pre_rst_valid", id_valid, 1);
    @(negedge clk); reset = 1'b1; settle();
    check("mid_rst_valid", id_valid, 0);
    check("mid_rst_instr", id_instr, 0);
    check("mid_rst_pc", id_pc, 0);
    @(negedge clk); reset = 1'b0; ex_ready = 1; settle();
    check("post_rst_ready", if_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
